// File: rtl/noise_seq_pkg.sv
// rtl/noise_seq_pkg.sv - shared FSM state type, LFSR constants and default pattern for noise_pattern_seq
package noise_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    localparam logic [15:0] DEFAULT_PAT_INIT = 16'h19AD;

    // Right-shifting Galois step: the taps are folded in whenever a one falls out of bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// rtl/noise_lfsr.sv - 16-bit Galois LFSR noise source, advances one step per enabled cycle
module noise_lfsr
    import noise_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] lfsr_q
);

    // LFSR register; the seed is nonzero so the sequence never locks up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (enable) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

endmodule

// File: rtl/noise_pattern_seq.sv
// rtl/noise_pattern_seq.sv - beat-driven per-channel noise pattern sequencer (optional LFSR noise via NOISE_SEQ_LFSR_EN)
module noise_pattern_seq
    import noise_seq_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          NUM_STEPS   = 16,
    parameter int          STEP_BEATS  = 4,
    parameter logic [63:0] DEFAULT_PAT = {48'h0, DEFAULT_PAT_INIT},
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         STEP_W      = $clog2(NUM_STEPS),
    localparam int         BEAT_W      = $clog2(NUM_STEPS * STEP_BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              one_shot,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [STEP_W-1:0] wr_step,
    input  logic              wr_val,
    output logic [NUM_CH-1:0] is_noise,
    output logic [BEAT_W-1:0] ibeat,
    output logic              wrap,
    output logic              busy,
    output logic [NUM_CH-1:0] noise_bit
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_STEPS * STEP_BEATS - 1);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [NUM_STEPS-1:0] pattern [NUM_CH];
    logic [STEP_W-1:0]    cur_step;
    logic                 last_beat;
    logic                 beat_adv;

    // The step is simply the upper bits of the beat number since STEP_BEATS is a power of two.
    assign cur_step  = ibeat[BEAT_W-1 -: STEP_W];
    assign last_beat = (ibeat == LAST_BEAT);
    // A beat only counts in RUN with pause low; start/stop in the same cycle override it.
    assign beat_adv  = (state == ST_RUN) && !pause && beat_tick && !stop && !start;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: stop beats start, start beats everything else.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (beat_tick && last_beat && one_shot) begin
                        state_next = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_PAUSE);
    end

    // Beat counter and wrap pulse; one-shot mode parks on the last beat instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibeat <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= beat_adv && last_beat && !one_shot;
            if (stop || start) begin
                ibeat <= '0;
            end else if (beat_adv) begin
                if (!last_beat) begin
                    ibeat <= ibeat + BEAT_W'(1);
                end else if (!one_shot) begin
                    ibeat <= '0;
                end
            end
        end
    end

    // Pattern store; writes to channels beyond NUM_CH match no row and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pattern[c] <= DEFAULT_PAT[NUM_STEPS-1:0];
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && (int'(wr_ch) == c)) begin
                    pattern[c][wr_step] <= wr_val;
                end
            end
        end
    end

    // Per-channel noise enable: follows the current step in RUN, frozen in PAUSE, cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_noise <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        is_noise[c] <= pattern[c][cur_step];
                    end
                end
                ST_PAUSE: is_noise <= is_noise;
                default:  is_noise <= '0;
            endcase
        end
    end

`ifdef NOISE_SEQ_LFSR_EN
    logic [15:0] lfsr_q;

    noise_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_RUN),
        .lfsr_q (lfsr_q)
    );

    assign noise_bit = lfsr_q[NUM_CH-1:0] & is_noise;
`else
    assign noise_bit = '0;
`endif

endmodule

// File: tb/tb_noise_pattern_seq.sv
// tb/tb_noise_pattern_seq.sv - scoreboard bench for noise_pattern_seq against a behavioural model
module tb_noise_pattern_seq;

    localparam int NUM_CH     = 3;
    localparam int NUM_STEPS  = 16;
    localparam int STEP_BEATS = 4;
    localparam int BEATS      = NUM_STEPS * STEP_BEATS;
    localparam int CHW        = 2;
    localparam int SW         = 4;
    localparam int BW         = 6;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic beat_tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, one_shot = 1'b0;
    logic wr_en = 1'b0, wr_val = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [SW-1:0]  wr_step = '0;
    logic [NUM_CH-1:0] is_noise, noise_bit;
    logic [BW-1:0] ibeat;
    logic wrap, busy;

    noise_pattern_seq #(
        .NUM_CH     (NUM_CH),
        .NUM_STEPS  (NUM_STEPS),
        .STEP_BEATS (STEP_BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_tick (beat_tick),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .one_shot  (one_shot),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_step   (wr_step),
        .wr_val    (wr_val),
        .is_noise  (is_noise),
        .ibeat     (ibeat),
        .wrap      (wrap),
        .busy      (busy),
        .noise_bit (noise_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                beat;
        logic [NUM_CH-1:0] noise;
        logic              wrap;
        logic              busy;
        logic [NUM_CH-1:0] nbit;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   wrap_seen = 0;
    bit   lfsr_seen = 1'b0;

    int                   m_mode;
    int                   m_beat;
    logic [NUM_STEPS-1:0] m_pat [NUM_CH];
    logic [NUM_CH-1:0]    m_noise;
    logic                 m_wrap;
    logic [15:0]          m_lfsr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_beat  = 0;
        m_noise = '0;
        m_wrap  = 1'b0;
        m_lfsr  = 16'hACE1;
        for (int c = 0; c < NUM_CH; c++) m_pat[c] = 16'h19AD;
    endtask

    // One clock of stimulus; the model predicts the outputs after the coming edge.
    task automatic cyc(input bit tk, input bit st, input bit sp, input bit ps, input bit os,
                       input bit we, input int wc, input int ws, input bit wv);
        exp_t e;
        int   prev_mode;
        @(negedge clk);
        beat_tick = tk; start = st; stop = sp; pause = ps; one_shot = os;
        wr_en = we; wr_ch = wc[CHW-1:0]; wr_step = ws[SW-1:0]; wr_val = wv;
        prev_mode = m_mode;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_mode == MD_RUN) m_noise[c] = m_pat[c][m_beat / STEP_BEATS];
            else if (m_mode != MD_PAUSE) m_noise[c] = 1'b0;
        end
        m_wrap = 1'b0;
        if (sp) begin
            m_mode = MD_IDLE; m_beat = 0;
        end else if (st) begin
            m_mode = MD_RUN; m_beat = 0;
        end else if (m_mode == MD_RUN) begin
            if (ps) m_mode = MD_PAUSE;
            else if (tk) begin
                if (m_beat == BEATS - 1) begin
                    if (os) m_mode = MD_DONE;
                    else begin m_beat = 0; m_wrap = 1'b1; end
                end else begin
                    m_beat = m_beat + 1;
                end
            end
        end else if (m_mode == MD_PAUSE && !ps) begin
            m_mode = MD_RUN;
        end
        if (we && wc < NUM_CH) m_pat[wc][ws] = wv;
        if (prev_mode == MD_RUN) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        e.beat  = m_beat;
        e.noise = m_noise;
        e.wrap  = m_wrap;
        e.busy  = (m_mode == MD_RUN) || (m_mode == MD_PAUSE);
`ifdef NOISE_SEQ_LFSR_EN
        e.nbit  = m_lfsr[NUM_CH-1:0] & m_noise;
`else
        e.nbit  = '0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit os = 1'b0);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, os, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input bit os = 1'b0);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, os, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ibeat"}, ibeat, 0);
        chk({tag, "_is_noise"}, is_noise, 0);
        chk({tag, "_wrap"}, wrap, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_noise_bit"}, noise_bit, 0);
    endtask

    // Monitor: compares every cycle for which the driver queued an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ibeat", ibeat, e.beat);
                chk("sb_is_noise", is_noise, e.noise);
                chk("sb_wrap", wrap, e.wrap);
                chk("sb_busy", busy, e.busy);
                chk("sb_noise_bit", noise_bit, e.nbit);
                if (wrap) wrap_seen++;
                if (noise_bit != '0) lfsr_seen = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        bit tk, st, sp, ps, os, we, wv;

        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Looping run over the default pattern.
        wrap_seen = 0;
        lfsr_seen = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < BEATS; i++) begin
            if (i % STEP_BEATS == 0) seq[i / STEP_BEATS] = is_noise[0];
`ifdef NOISE_SEQ_LFSR_EN
            if (i == 4) chk("lfsr_nonzero", lfsr_seen, 1);
`endif
            ticks(1);
            idle(2);
        end
        chk("step_seq_ch0", seq, 16'h19AD);
        chk("wrap_count", wrap_seen, 1);
        chk("loop_ibeat_end", ibeat, 0);

        // One-shot run stops on the last beat.
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
        ticks(BEATS, 1);
        idle(3, 1);
        chk("oneshot_busy", busy, 0);
        chk("oneshot_ibeat", ibeat, BEATS - 1);
        chk("oneshot_is_noise", is_noise, 0);
        ticks(5, 1);
        idle(2, 1);
        chk("oneshot_extra_ticks", ibeat, BEATS - 1);

        // Pause at beat 5 for ten ticks.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        ticks(5);
        idle(2);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("pause_ibeat", ibeat, 5);
        chk("pause_busy", busy, 1);
        chk("pause_is_noise", is_noise, 0);
        idle(1);
        ticks(1);
        idle(1);
        chk("pause_release_ibeat", ibeat, 6);

        // Write into the step currently playing.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        ticks(9);
        idle(2);
        chk("step2_before_write", is_noise, 3'b111);
        cyc(0, 0, 0, 0, 0, 1, 1, 2, 0);
        idle(2);
        chk("write_ch1_dropped", is_noise[1], 0);
        chk("write_ch0_kept", is_noise[0], 1);

        // start and stop together, then an asynchronous reset mid-run.
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("startstop_busy", busy, 0);
        chk("startstop_ibeat", ibeat, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        ticks(7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        ticks(9);
        idle(2);
        chk("reset_restores_pat", is_noise[1], 1);

        // Randomised traffic, including writes to an out-of-range channel.
        ps = 1'b0;
        os = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            tk = ($urandom % 3) == 0;
            st = ($urandom % 60) == 0;
            sp = ($urandom % 97) == 0;
            if (($urandom % 20) == 0) ps = ~ps;
            if (($urandom % 150) == 0) os = ~os;
            we = ($urandom % 6) == 0;
            wv = $urandom % 2;
            cyc(tk, st, sp, ps, os, we, $urandom % 4, $urandom % NUM_STEPS, wv);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/noise_pattern_seq.md
NOISE_PATTERN_SEQ -- requirements
Module: noise_pattern_seq

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent noise channels (1..8).
REQ-002 Parameter NUM_STEPS, default 16, pattern steps per loop (power of 2, 2..64).
REQ-003 Parameter STEP_BEATS, default 4, beats per step (power of 2, 1..16).
REQ-004 Parameter DEFAULT_PAT, default 16'h19AD, reset pattern for every channel, bit i = step i.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 beat_tick  in  1  single-cycle pulse, one per beat.
REQ-008 start  in  1  pulse; begin/restart the sequence at beat 0.
REQ-009 stop  in  1  pulse; abort to IDLE.
REQ-010 pause  in  1  level; freeze the beat counter while high.
REQ-011 one_shot  in  1  level; 1 = stop after the last beat, 0 = loop.
REQ-012 wr_en, wr_ch, wr_step, wr_val  in  1/clog2(NUM_CH)/clog2(NUM_STEPS)/1  pattern bit write port.
REQ-013 is_noise  out  NUM_CH  registered per-channel noise enable.
REQ-014 ibeat  out  clog2(NUM_STEPS*STEP_BEATS)  current beat number.
REQ-015 wrap  out  1  one-cycle pulse when ibeat wraps from last to 0 in loop mode.
REQ-016 busy  out  1  high in RUN or PAUSE.
REQ-017 noise_bit  out  NUM_CH  per-channel pseudo-random bit (see Configuration).

Function
REQ-018 FSM states IDLE, RUN, PAUSE, DONE; start from any state -> RUN with ibeat=0.
REQ-019 stop -> IDLE from any state; stop takes priority over start in the same cycle.
REQ-020 RUN with pause=1 -> PAUSE; PAUSE with pause=0 -> RUN; beat_tick ignored in PAUSE, IDLE, DONE.
REQ-021 In RUN, beat_tick increments ibeat by 1 with 1-cycle latency.
REQ-022 At ibeat = last beat with beat_tick: loop mode -> ibeat=0, wrap=1 for one cycle; one_shot -> DONE, ibeat holds last value.
REQ-023 Step index = ibeat / STEP_BEATS (upper bits of ibeat, no divider).
REQ-024 is_noise[c] = pattern[c][step] registered, updated the cycle after ibeat changes; forced 0 in IDLE and DONE, held in PAUSE.
REQ-025 Write stores wr_val in pattern[wr_ch][wr_step] at the clock edge in any state; out-of-range wr_ch ignored.
REQ-026 Write to the current step is visible on is_noise no later than 2 cycles after wr_en.
REQ-027 start coincident with beat_tick: restart wins, ibeat=0.

Reset
REQ-028 rst_n low asynchronously: state IDLE, ibeat 0, is_noise 0, wrap 0, busy 0, noise_bit 0, every channel pattern = DEFAULT_PAT[NUM_STEPS-1:0].
REQ-029 Reset mid-RUN discards all pattern writes and restores defaults.

Configuration
REQ-030 With NOISE_SEQ_LFSR_EN defined: one 16-bit Galois LFSR (taps 0xB400, seed 0xACE1), advancing every clk in RUN; noise_bit[c] = LFSR bit c AND is_noise[c].
REQ-031 Without NOISE_SEQ_LFSR_EN: no LFSR logic; noise_bit tied to 0.

Structure
REQ-032 Package noise_seq_pkg holds the FSM state enum, LFSR taps/seed constants, and DEFAULT_PAT default.
REQ-033 Sub-module noise_lfsr (enable, 16-bit state out), instantiated only under NOISE_SEQ_LFSR_EN.

Verification
REQ-034 Defaults, start, 64 beat_ticks loop mode: is_noise[0] sequence per step = 1,0,1,1,0,1,0,1,1,0,0,1,1,0,0,0; wrap pulses once after beat 63.
REQ-035 one_shot=1, 64 beat_ticks: DONE after tick 64, busy=0, ibeat=63, is_noise=0; extra ticks ignored.
REQ-036 pause high for 10 ticks at ibeat=5: ibeat stays 5, is_noise held; release -> next tick ibeat=6.
REQ-037 Write ch1 step2=0 while ibeat=9 (step 2): is_noise[1] drops within 2 cycles; ch0 unchanged.
REQ-038 start and stop same cycle in RUN -> IDLE, ibeat=0; rst_n low mid-RUN -> all outputs 0 immediately, patterns default.
REQ-039 With NOISE_SEQ_LFSR_EN: noise_bit nonzero within 20 cycles of RUN, 0 on channels with is_noise=0; without the macro noise_bit stays 0.
